// File: rtl/main_mem_responder.sv
// Backing-memory responder for the data cache refill/writeback port: one line per request,
// fixed access latency, single-word beats. Optional range check: MAIN_MEM_ADDR_CHECK_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a request, response outputs idle
// RD_WAIT  | refill accepted, counting down the access latency
// RD_BURST | presenting refill beats, advancing on rsp handshake
// WR_BURST | consuming writeback beats into the backing store
// WR_WAIT  | last write beat taken, counting down the access latency
// ACK      | presenting the single write acknowledge beat
module main_mem_responder #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_WORDS      = 4096,
    parameter int LATENCY        = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_last_o,
    output logic                  rsp_err_o
);

    localparam int BEAT_W    = $clog2(WORDS_PER_LINE);
    localparam int MEM_IDX_W = $clog2(MEM_WORDS);
    localparam int LINE_W    = MEM_IDX_W - BEAT_W;
    localparam int LINE_OFF  = BEAT_W + 2;
    localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
    localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] BAD_WORD  = DATA_WIDTH'(32'hDEADBEEF);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_WAIT,
        ACK
    } stateT;

    stateT                 state;
    logic [LINE_W-1:0]     lineIdx;
    logic [BEAT_W-1:0]     beat;
    logic [BEAT_W-1:0]     beatNext;
    logic [CNT_W-1:0]      latCnt;
    logic                  errFlag;
    logic                  rangeErr;
    logic                  unusedAddr;
    logic [MEM_IDX_W-1:0]  memIdx;
    logic [MEM_IDX_W-1:0]  nextIdx;
    logic [DATA_WIDTH-1:0] readWord;
    logic [DATA_WIDTH-1:0] readNext;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

`ifdef MAIN_MEM_ADDR_CHECK_EN
    // Any address bit above the backing store's word range means the line is out of range.
    assign rangeErr   = |req_addr_i[ADDR_WIDTH-1:MEM_IDX_W+2];
    assign unusedAddr = ^req_addr_i[LINE_OFF-1:0];
`else
    assign rangeErr   = 1'b0;
    assign unusedAddr = ^{req_addr_i[ADDR_WIDTH-1:MEM_IDX_W+2], req_addr_i[LINE_OFF-1:0]};
`endif

    assign req_ready_o = (state == IDLE);
    assign wr_ready_o  = (state == WR_BURST);

    assign beatNext = beat + BEAT_ONE;
    assign memIdx   = {lineIdx, beat};
    assign nextIdx  = {lineIdx, beatNext};
    assign readWord = errFlag ? BAD_WORD : mem[memIdx];
    assign readNext = errFlag ? BAD_WORD : mem[nextIdx];

    // Backing store is deliberately not reset; committed beats survive a mid-transaction reset.
    always_ff @(posedge clk_i) begin
        if (state == WR_BURST && wr_valid_i && !errFlag) begin
            mem[memIdx] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            lineIdx     <= '0;
            beat        <= '0;
            latCnt      <= '0;
            errFlag     <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_last_o  <= 1'b0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        lineIdx <= req_addr_i[LINE_OFF +: LINE_W];
                        errFlag <= rangeErr;
                        beat    <= '0;
                        if (req_we_i) begin
                            state <= WR_BURST;
                        end else begin
                            latCnt <= CNT_LOAD;
                            state  <= RD_WAIT;
                        end
                    end
                end

                RD_WAIT: begin
                    if (latCnt == '0) begin
                        state       <= RD_BURST;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= readWord;
                        rsp_last_o  <= (beat == LAST_BEAT);
                        rsp_err_o   <= errFlag;
                    end else begin
                        latCnt <= latCnt - CNT_ONE;
                    end
                end

                RD_BURST: begin
                    if (rsp_ready_i) begin
                        if (beat == LAST_BEAT) begin
                            state       <= IDLE;
                            beat        <= '0;
                            rsp_valid_o <= 1'b0;
                            rsp_data_o  <= '0;
                            rsp_last_o  <= 1'b0;
                            rsp_err_o   <= 1'b0;
                        end else begin
                            beat       <= beatNext;
                            rsp_data_o <= readNext;
                            rsp_last_o <= (beatNext == LAST_BEAT);
                        end
                    end
                end

                WR_BURST: begin
                    if (wr_valid_i) begin
                        if (beat == LAST_BEAT) begin
                            beat   <= '0;
                            latCnt <= CNT_LOAD;
                            state  <= WR_WAIT;
                        end else begin
                            beat <= beatNext;
                        end
                    end
                end

                WR_WAIT: begin
                    if (latCnt == '0) begin
                        state       <= ACK;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= '0;
                        rsp_last_o  <= 1'b1;
                        rsp_err_o   <= errFlag;
                    end else begin
                        latCnt <= latCnt - CNT_ONE;
                    end
                end

                ACK: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_last_o  <= 1'b0;
                        rsp_err_o   <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    rsp_valid_o <= 1'b0;
                    rsp_data_o  <= '0;
                    rsp_last_o  <= 1'b0;
                    rsp_err_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule
